// File: rtl/eth_fcs_insert.sv
// eth_fcs_insert
//   Transmit-side Ethernet FCS sequencer. Forwards one byte-wide AXI-stream
//   frame at a time. When padding is compiled in, it zero-pads short frames
//   up to MIN_FRAME_LEN bytes. It then appends the 4-byte CRC32 FCS
//   (reflected polynomial 32'hedb88320, init 32'hffffffff, output inverted,
//   least significant byte first).
//
//   Build option: define ETH_FCS_INSERT_PAD_EN to compile in the PAD state.
//   When it is undefined, MIN_FRAME_LEN is used only for its range check.
//
//   Ports:
//     clk, rst           sole clock; synchronous active-high reset
//     s_axis_tdata/tvalid/tready/tlast/tuser   payload input, tuser sampled with tlast
//     m_axis_tdata/tvalid/tready/tlast/tuser   output slot, tlast/tuser on final FCS beat
module eth_fcs_insert #(
  parameter int MIN_FRAME_LEN = 32'sd60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
);

  generate
    if (MIN_FRAME_LEN < 32'sd1 || MIN_FRAME_LEN > 32'sd63) begin : g_min_len_bad
      $error("eth_fcs_insert: MIN_FRAME_LEN must be in 1..63");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
`ifdef ETH_FCS_INSERT_PAD_EN
    ST_PAD  = 2'd1,
`endif
    ST_FCS  = 2'd2
  } state_t;

  // One byte of the reflected CRC32: the data byte is folded into the low
  // bits, then the register is shifted right eight times. The data enters
  // LSB first.
  function automatic logic [31:0] crc8_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    return c;
  endfunction

  state_t      state;
  logic [31:0] crc_state;
  logic [1:0]  fcs_idx;
  logic        err_latch;
  logic        load;
  logic [7:0]  crc_din;
  logic [31:0] crc_next;
  logic [7:0]  fcs_byte;

`ifdef ETH_FCS_INSERT_PAD_EN
  localparam logic [6:0] MIN_LEN = 7'(MIN_FRAME_LEN);
  logic [5:0] byte_cnt;
  logic [6:0] cnt_inc;    // one bit wider so 63+1 cannot wrap in the compare

  assign cnt_inc = {1'b0, byte_cnt} + 7'd1;
  assign crc_din = (state == ST_PAD) ? 8'h00 : s_axis_tdata;
`else
  assign crc_din = s_axis_tdata;
`endif

  // The slot can take a new beat when it is empty or its beat leaves this cycle.
  assign load          = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = (state == ST_DATA) && load && !rst;
  assign crc_next      = crc8_step(crc_state, crc_din);

  // Select the FCS byte for fcs_idx from the inverted CRC register.
  always_comb begin
    fcs_byte = 8'h00;
    case (fcs_idx)
      2'd0:    fcs_byte = ~crc_state[7:0];
      2'd1:    fcs_byte = ~crc_state[15:8];
      2'd2:    fcs_byte = ~crc_state[23:16];
      2'd3:    fcs_byte = ~crc_state[31:24];
      default: fcs_byte = 8'h00;
    endcase
  end

  // Frame sequencer, CRC register, and output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_DATA;
      crc_state     <= 32'hffffffff;
      fcs_idx       <= 2'd0;
      err_latch     <= 1'b0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
`ifdef ETH_FCS_INSERT_PAD_EN
      byte_cnt      <= 6'd0;
`endif
    end else if (load) begin
      case (state)
        ST_DATA: begin
          if (s_axis_tvalid) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            crc_state     <= crc_next;
`ifdef ETH_FCS_INSERT_PAD_EN
            byte_cnt      <= (byte_cnt == 6'd63) ? 6'd63 : cnt_inc[5:0];
`endif
            if (s_axis_tlast) begin
              err_latch <= s_axis_tuser;
              fcs_idx   <= 2'd0;
`ifdef ETH_FCS_INSERT_PAD_EN
              state     <= (cnt_inc < MIN_LEN) ? ST_PAD : ST_FCS;
`else
              state     <= ST_FCS;
`endif
            end
          end else begin
            m_axis_tvalid <= 1'b0;
          end
        end
`ifdef ETH_FCS_INSERT_PAD_EN
        ST_PAD: begin
          m_axis_tdata  <= 8'h00;
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= 1'b0;
          m_axis_tuser  <= 1'b0;
          crc_state     <= crc_next;
          byte_cnt      <= (byte_cnt == 6'd63) ? 6'd63 : cnt_inc[5:0];
          if (cnt_inc == MIN_LEN) begin
            state <= ST_FCS;
          end
        end
`endif
        ST_FCS: begin
          // crc_state holds still here until the last FCS byte loads.
          m_axis_tdata  <= fcs_byte;
          m_axis_tvalid <= 1'b1;
          fcs_idx       <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= err_latch;
            crc_state    <= 32'hffffffff;
            err_latch    <= 1'b0;
            state        <= ST_DATA;
`ifdef ETH_FCS_INSERT_PAD_EN
            byte_cnt     <= 6'd0;
`endif
          end else begin
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= 1'b0;
          end
        end
        default: begin
          state         <= ST_DATA;
          m_axis_tvalid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_fcs_insert.sv
// Self-checking bench for eth_fcs_insert. A queue-based reference model
// computes the expected output stream. For each frame it takes the payload,
// zero-pads it when the pad build is selected, and appends a bit-serial
// CRC32 FCS.
module tb_eth_fcs_insert;
  localparam int MIN_LEN = 60;
`ifdef ETH_FCS_INSERT_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic       s_axis_tlast;
  logic       s_axis_tuser;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic       m_axis_tuser;

  always #5 clk = ~clk;

  eth_fcs_insert #(.MIN_FRAME_LEN(MIN_LEN)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser)
  );

  logic [9:0] src_q[$];   // {tuser, tlast, data}
  logic [9:0] exp_q[$];   // {tuser, tlast, data}
  int         checks = 0;
  int         errors = 0;
  int         accepted = 0;
  int         beats = 0;
  bit         rdy_rand = 1'b0;
  bit         streaming = 1'b0;
  bit         hold_prev = 1'b0;
  logic [9:0] hold_val = 10'd0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Standard bit-at-a-time reflected CRC32 over a whole byte sequence.
  function automatic logic [31:0] crc32_of(input logic [7:0] fr[$]);
    logic [31:0] c;
    logic        fb;
    c = 32'hffffffff;
    foreach (fr[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ fr[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hedb88320;
      end
    end
    return ~c;
  endfunction

  task automatic push_src(input logic [7:0] pl[$], input bit usr);
    for (int i = 0; i < pl.size(); i++) begin
      src_q.push_back({usr && (i == pl.size() - 1), i == pl.size() - 1, pl[i]});
    end
  endtask

  task automatic push_exp_model(input logic [7:0] pl[$], input bit usr);
    logic [7:0]  fr[$];
    logic [31:0] fcs;
    fr = pl;
    if (PAD_EN) begin
      while (fr.size() < MIN_LEN) fr.push_back(8'h00);
    end
    fcs = crc32_of(fr);
    foreach (fr[k]) exp_q.push_back({2'b00, fr[k]});
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({usr && (k == 3), k == 3, fcs[8*k +: 8]});
    end
  endtask

  task automatic push_frame(input logic [7:0] pl[$], input bit usr);
    push_src(pl, usr);
    push_exp_model(pl, usr);
  endtask

  task automatic rand_payload(input int len, output logic [7:0] pl[$]);
    pl = {};
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  // "123456789" plus its expected output. In the unpadded build the FCS
  // bytes are the published check-value constants.
  task automatic push_check_vector();
    logic [7:0] pl[$];
    pl = {};
    for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
    push_src(pl, 1'b0);
`ifdef ETH_FCS_INSERT_PAD_EN
    push_exp_model(pl, 1'b0);
`else
    foreach (pl[k]) exp_q.push_back({2'b00, pl[k]});
    exp_q.push_back({2'b00, 8'h26});
    exp_q.push_back({2'b00, 8'h39});
    exp_q.push_back({2'b00, 8'hF4});
    exp_q.push_back({2'b01, 8'hCB});
`endif
  endtask

  // One clock: drive at the falling edge, then sample 1 ns later.
  task automatic step();
    @(negedge clk);
    m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (src_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      {s_axis_tuser, s_axis_tlast, s_axis_tdata} = src_q[0];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
    end
    #1;
    if (hold_prev) begin
      check_value("hold_valid", 32'(m_axis_tvalid), 32'd1);
      check_value("hold_beat", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(hold_val));
    end
    if (streaming && exp_q.size() > 0) check_value("no_bubble", 32'(m_axis_tvalid), 32'd1);
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check_value("extra_beat", 32'(m_axis_tvalid), 32'd0);
      end else begin
        check_value("beat", 32'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 32'(exp_q.pop_front()));
      end
      beats++;
      streaming = 1'b1;
    end
    hold_prev = m_axis_tvalid && !m_axis_tready;
    hold_val  = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
    if (s_axis_tvalid && s_axis_tready) begin
      void'(src_q.pop_front());
      accepted++;
    end
  endtask

  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    streaming = 1'b0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check_value("run_done", 32'(src_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] pl[$];
    int         len;
    int         n;

    // Reset: hold for a few cycles with the source already offering data.
    rst = 1'b1;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 8'h5a;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_value("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check_value("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_value("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    check_value("rst_m_tuser", 32'(m_axis_tuser), 32'd0);
    check_value("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check_value("post_rst_s_tready", 32'(s_axis_tready), 32'd1);

    // Check vector with full throughput.
    beats = 0;
    push_check_vector();
    run_until_done(200);
    check_value("vec_beats", 32'(beats), PAD_EN ? 32'd64 : 32'd13);

    // No-pad boundary (60 bytes) and one-pad boundary (59 bytes).
    beats = 0;
    rand_payload(60, pl);
    push_frame(pl, 1'b0);
    run_until_done(300);
    check_value("len60_beats", 32'(beats), 32'd64);
    beats = 0;
    rand_payload(59, pl);
    push_frame(pl, 1'b0);
    run_until_done(300);
    check_value("len59_beats", 32'(beats), PAD_EN ? 32'd64 : 32'd63);

    // Two back-to-back 64-byte frames with random backpressure.
    rdy_rand = 1'b1;
    rand_payload(64, pl);
    push_frame(pl, 1'b0);
    rand_payload(64, pl);
    push_frame(pl, 1'b0);
    run_until_done(2000);

    // Error flag frame followed by a clean frame.
    rand_payload(17, pl);
    push_frame(pl, 1'b1);
    rand_payload(5, pl);
    push_frame(pl, 1'b0);
    run_until_done(1000);

    // Random lengths, including a single-byte frame and random error flags.
    rand_payload(1, pl);
    push_frame(pl, 1'($urandom_range(0, 1)));
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 70);
      rand_payload(len, pl);
      push_frame(pl, 1'($urandom_range(0, 1)));
    end
    run_until_done(6000);

    // Mid-frame reset after 20 accepted payload bytes.
    rdy_rand = 1'b0;
    rand_payload(40, pl);
    push_frame(pl, 1'b0);
    accepted = 0;
    n = 0;
    streaming = 1'b0;
    while (accepted < 20 && n < 200) begin
      step();
      n++;
    end
    check_value("mid_accepted", 32'(accepted), 32'd20);
    @(negedge clk);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    src_q = {};
    exp_q = {};
    hold_prev = 1'b0;
    #1;
    check_value("mid_rst_s_tready", 32'(s_axis_tready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_value("mid_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_value("mid_rst_s_tready_up", 32'(s_axis_tready), 32'd1);
    beats = 0;
    push_check_vector();
    run_until_done(200);
    check_value("vec2_beats", 32'(beats), PAD_EN ? 32'd64 : 32'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
